// File: rtl/uart_8n1_rx.sv
// 8N1 UART receiver: 16x oversampling, majority vote per bit,
// one-entry holding register with framing-error and overrun status.
module uart_8n1_rx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 rx,
    output logic [7:0]           rx_data,
    output logic                 rx_full,
    output logic                 rx_empty,
    output logic                 rx_error,
    output logic                 rx_overrun,
    input  logic                 rx_read
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] tcnt;
    logic [3:0]           scnt;
    logic [2:0]           bit_idx;
    logic                 v7;
    logic                 v8;
    logic [7:0]           shreg;
    logic                 fall;
    logic                 tick;
    logic                 maj;
    logic                 go;
    logic                 shift;
    logic                 bit_end;
    logic                 done;
    logic                 accept;

    assign fall     = rx_prev & ~rx_s2;
    assign tick     = (state != IDLE) && (tcnt == div_q - DIV_WIDTH'(1));
    assign maj      = (v7 & v8) | (v7 & rx_s2) | (v8 & rx_s2);
    assign rx_empty = ~rx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fall) state_nxt = START;
            end
            START: begin
                if (tick && scnt == 4'd9 && maj)
                    state_nxt = IDLE;
                else if (tick && scnt == 4'd15)
                    state_nxt = DATA;
            end
            DATA: begin
                if (tick && scnt == 4'd15 && bit_idx == 3'd7)
                    state_nxt = STOP;
            end
            STOP: begin
                if (tick && scnt == 4'd9) state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        go      = (state == IDLE) && fall;
        shift   = (state == DATA) && tick && scnt == 4'd9;
        bit_end = (state == DATA) && tick && scnt == 4'd15;
        done    = (state == STOP) && tick && scnt == 4'd9;
        accept  = done && (!rx_full || rx_read);
    end

    // Synchroniser idles high so reset never looks like a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= DIV_WIDTH'(1);
            tcnt    <= '0;
            scnt    <= '0;
            bit_idx <= '0;
            v7      <= 1'b0;
            v8      <= 1'b0;
            shreg   <= '0;
        end else begin
            if (go) begin
                div_q   <= (divisor == '0) ? DIV_WIDTH'(1) : divisor;
                tcnt    <= '0;
                scnt    <= '0;
                bit_idx <= '0;
            end else if (state != IDLE) begin
                if (tick) begin
                    tcnt <= '0;
                    scnt <= scnt + 4'd1;
                    if (scnt == 4'd7) v7 <= rx_s2;
                    if (scnt == 4'd8) v8 <= rx_s2;
                end else begin
                    tcnt <= tcnt + DIV_WIDTH'(1);
                end
            end
            if (shift) shreg <= {maj, shreg[7:1]};
            if (bit_end) bit_idx <= bit_idx + 3'd1;
        end
    end

    // A read in the completion cycle frees the slot for the new byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_full    <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (accept) begin
            rx_data    <= shreg;
            rx_error   <= ~maj;
            rx_full    <= 1'b1;
            rx_overrun <= 1'b0;
        end else if (done) begin
            rx_overrun <= 1'b1;
        end else if (rx_read && rx_full) begin
            rx_full    <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_8n1_rx.sv
// Bench for uart_8n1_rx: frames driven at 32 clk/bit, received bytes
// checked against a queue of expected {data, error} entries.
module tb_uart_8n1_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] divisor = 16'd2;
    logic        rx = 1'b1;
    logic        rx_read = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_error;
    logic        rx_overrun;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic       mon_full;
    logic [7:0] mon_data;
    logic       mon_err;
    int         n_tests = 0;
    int         n_fail = 0;

    uart_8n1_rx #(.DIV_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .divisor    (divisor),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_full    (rx_full),
        .rx_empty   (rx_empty),
        .rx_error   (rx_error),
        .rx_overrun (rx_overrun),
        .rx_read    (rx_read)
    );

    always #5 clk = ~clk;

    // Every new load of the holding register pops one expected entry
    always @(negedge clk) begin
        if (!reset) begin
            mon_full = 1'b0;
            mon_data = 8'h00;
            mon_err  = 1'b0;
        end else begin
            if (rx_full && (!mon_full || rx_data !== mon_data ||
                            rx_error !== mon_err)) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got data=%h err=%b, none expected",
                             rx_data, rx_error);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({rx_data, rx_error} !== {mon_e.d, mon_e.e}) begin
                        n_fail++;
                        $display("FAIL sb_byte: got data=%h err=%b, expected data=%h err=%b",
                                 rx_data, rx_error, mon_e.d, mon_e.e);
                    end
                end
            end
            mon_full = rx_full;
            mon_data = rx_data;
            mon_err  = rx_error;
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (32) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic push);
        exp_t e;
        e.d = b;
        e.e = ~stop;
        if (push) exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rx_data, rx_full, rx_empty, rx_error, rx_overrun} !==
            {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got %h %b %b %b %b, expected 00 0 1 0 0",
                     rx_data, rx_full, rx_empty, rx_error, rx_overrun);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        pulse_read();
        @(negedge clk);
        n_tests++;
        if ({rx_full, rx_empty, rx_overrun} !== 3'b010) begin
            n_fail++;
            $display("FAIL read_empty: got full=%b empty=%b ovr=%b, expected 0 1 0",
                     rx_full, rx_empty, rx_overrun);
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b1);
        n_tests++;
        if ({rx_full, rx_data, rx_error, rx_overrun} !== {1'b1, 8'hA5, 2'b00}) begin
            n_fail++;
            $display("FAIL basic_a5: got full=%b data=%h err=%b ovr=%b, expected 1 a5 0 0",
                     rx_full, rx_data, rx_error, rx_overrun);
        end
        pulse_read();
        n_tests++;
        if ({rx_full, rx_empty} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_read: got full=%b empty=%b, expected 0 1",
                     rx_full, rx_empty);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        rx_read = 1'b1;
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        rx_read = 1'b0;
        n_tests++;
        if ({rx_full, rx_overrun, rx_error} !== 3'b000) begin
            n_fail++;
            $display("FAIL sweep_flags: got full=%b ovr=%b err=%b, expected 0 0 0",
                     rx_full, rx_overrun, rx_error);
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b1);
        n_tests++;
        if ({rx_full, rx_data, rx_error} !== {1'b1, 8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL frame_err: got full=%b data=%h err=%b, expected 1 3c 1",
                     rx_full, rx_data, rx_error);
        end
        pulse_read();
        n_tests++;
        if ({rx_full, rx_error} !== 2'b00) begin
            n_fail++;
            $display("FAIL frame_read: got full=%b err=%b, expected 0 0",
                     rx_full, rx_error);
        end
        repeat (64) @(negedge clk);
        n_tests++;
        if (rx_full !== 1'b0) begin
            n_fail++;
            $display("FAIL break_hold: got full=%b, expected 0", rx_full);
        end
        drive_bit(1'b1);
        send_frame(8'h81, 1'b1, 1'b1);
        n_tests++;
        if ({rx_full, rx_data, rx_error} !== {1'b1, 8'h81, 1'b0}) begin
            n_fail++;
            $display("FAIL after_break: got full=%b data=%h err=%b, expected 1 81 0",
                     rx_full, rx_data, rx_error);
        end
        pulse_read();
        wait_drain();
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        n_tests++;
        if (rx_full !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got full=%b, expected 0", rx_full);
        end
        send_frame(8'h55, 1'b1, 1'b1);
        n_tests++;
        if ({rx_full, rx_data, rx_error} !== {1'b1, 8'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL glitch_55: got full=%b data=%h err=%b, expected 1 55 0",
                     rx_full, rx_data, rx_error);
        end
        pulse_read();
        wait_drain();
    endtask

    task automatic test_overrun();
        logic [9:0] fr;
        exp_t       e;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        n_tests++;
        if ({rx_full, rx_data, rx_overrun} !== {1'b1, 8'h11, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun: got full=%b data=%h ovr=%b, expected 1 11 1",
                     rx_full, rx_data, rx_overrun);
        end
        pulse_read();
        n_tests++;
        if ({rx_full, rx_overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL ovr_clear: got full=%b ovr=%b, expected 0 0",
                     rx_full, rx_overrun);
        end
        send_frame(8'h44, 1'b1, 1'b1);
        // Completion lands on the tick in the cycle before negedge 311
        fr = {1'b1, 8'h33, 1'b0};
        e.d = 8'h33;
        e.e = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < 320; i++) begin
            rx = fr[i / 32];
            rx_read = (i == 310);
            @(negedge clk);
        end
        rx_read = 1'b0;
        n_tests++;
        if ({rx_full, rx_data, rx_overrun} !== {1'b1, 8'h33, 1'b0}) begin
            n_fail++;
            $display("FAIL read_on_done: got full=%b data=%h ovr=%b, expected 1 33 0",
                     rx_full, rx_data, rx_overrun);
        end
        pulse_read();
        wait_drain();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h5A;
        send_frame(8'h99, 1'b1, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rx_data, rx_full, rx_empty, rx_error, rx_overrun} !==
            {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h %b %b %b %b, expected 00 0 1 0 0",
                     rx_data, rx_full, rx_empty, rx_error, rx_overrun);
        end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h7E, 1'b1, 1'b1);
        n_tests++;
        if ({rx_full, rx_data, rx_error, rx_overrun} !== {1'b1, 8'h7E, 2'b00}) begin
            n_fail++;
            $display("FAIL post_reset: got full=%b data=%h err=%b ovr=%b, expected 1 7e 0 0",
                     rx_full, rx_data, rx_error, rx_overrun);
        end
        pulse_read();
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_8n1_rx.md
Name: uart_8n1_rx

Overview:
Standalone 8N1 UART receiver: the line-side receive end for the serial stream produced by the uart_8n1 transmitter.
- Oversamples rx at 16x the bit rate, majority-votes each bit, validates start and stop bits.
- Delivers each byte through a one-entry holding register with full/empty/error/overrun status.
- Used where only a receive path is needed, e.g. a debug command input, or as a reference receiver on the line in transmitter benches.

Parameters:
DIV_WIDTH, 16, width of the divisor input.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
divisor  input  DIV_WIDTH  clk cycles per oversample tick (1/16 bit); 0 treated as 1; sampled only in IDLE.
rx  input  1  serial line, idle high; asynchronous to clk.
rx_data  output  8  received byte; valid while rx_full=1.
rx_full  output  1  holding register occupied.
rx_empty  output  1  always ~rx_full.
rx_error  output  1  framing error flag for the byte in rx_data (stop bit sampled low).
rx_overrun  output  1  sticky: a completed byte was dropped because the holding register was full.
rx_read  input  1  consume the held byte; ignored when rx_full=0.

Behaviour:
- Reset (reset=0, async): rx_data=0, rx_full=0, rx_empty=1, rx_error=0, rx_overrun=0. FSM goes to IDLE; synchroniser flops are set to 1; all counters are cleared. A reset mid-frame discards the partial byte.
- rx passes through a 2-flop synchroniser, reset value 1. Edge detection uses the synchronised value and its previous value.
- Tick generator: counts 0..divisor-1 and pulses tick on the terminal count. It reloads to 0 on start detection, so tick 0 of the start bit falls divisor clks after the edge.
- Sample counter s: 0..15 within each bit, advancing on tick. Bit value = majority of samples at s=7,8,9, latched at s=9.
- FSM:
  - IDLE: on synchronised 1->0, go to START with s=0 and the bit index cleared.
  - START: at s=9, majority 1 means a false start: return to IDLE, no output, no flags. Majority 0 continues; at s=15 go to DATA.
  - DATA: 8 bits, LSB first, shifted in at s=9 of each bit. After bit 7 completes (s=15), go to STOP.
  - STOP: at s=9, complete the frame (see below) and return to IDLE immediately. The second half of the stop bit is not waited out, so a back-to-back start edge is caught.
- Frame completion (one clk, at STOP s=9 tick):
  - If rx_full=0, or rx_read=1 in the same cycle: load rx_data, set rx_error = ~stop_majority, set rx_full=1 next clk.
  - If rx_full=1 and rx_read=0: drop the byte, keep rx_data/rx_error unchanged, set rx_overrun=1.
- rx_read with rx_full=1 and no completion: rx_full=0 next clk, rx_error cleared, rx_overrun cleared.
- rx_read while rx_full=0: no effect.
- Framing error with the line held low (break): the byte is delivered with rx_error=1. No new start is recognised until rx has returned high and fallen again.
- Latency: rx_full rises 1 clk after the STOP s=9 tick, i.e. about 9.5 bit times after the start edge plus 2 synchroniser clks.
- A divisor change takes effect only at the next start detection.

Test Plan:
- Setup for all scenarios: divisor=2 (32 clk/bit). The driver bench sends frames with the same timing.
- Send 0xA5 with a valid stop bit, rx_read=0 -> rx_full=1, rx_data=0xA5, rx_error=0, rx_overrun=0; pulse rx_read -> rx_full=0 next clk.
- Sweep bytes 0x00..0xFF back-to-back with zero idle between frames, rx_read tied 1 -> every byte received in order, no errors, no overrun.
- Frame 0x3C with stop bit forced low -> rx_data=0x3C, rx_error=1. Then send 0x81 after the line has been high for 1 bit -> rx_data=0x81, rx_error=0.
- Low glitch of 10 clk (less than half a bit) on an idle line -> no rx_full, FSM back in IDLE; a following valid 0x55 is received correctly.
- Send 0x11 then 0x22 without reading -> rx_data=0x11, rx_overrun=1. rx_read -> rx_full=0, rx_overrun=0. Then send 0x33 with rx_read asserted exactly on the completion cycle while full -> rx_data=0x33, rx_full stays 1, rx_overrun=0.
- Assert reset=0 at bit 4 of a frame, release, then send 0x7E -> all outputs at reset values during reset, partial byte discarded, 0x7E received cleanly.
